// File: rtl/sdram_request_port_if.sv
// Signal bundle linking the Hack CPU memory port, the SDRAM request FIFO and the RAM manager.
// slave is the requester's view; master is the surrounding CPU/FIFO/manager environment.
interface sdram_request_port_if #(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned DATA_W = 16
);
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_we;
   logic              cpu_re;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready;
   logic              cpu_busy;
   logic              cpu_err;
   logic [ADDR_W-1:0] sdram_buffer_addr_in;
   logic [DATA_W-1:0] sdram_buffer_data_in;
   logic              sdram_buffer_rw_in;
   logic              sdram_buffer_wrreq;
   logic              sdram_buffer_full;
   logic              sdram_buffer_empty;
   logic [DATA_W-1:0] data_output;
   logic [ADDR_W-1:0] current_address;

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
      input  sdram_buffer_full, sdram_buffer_empty, data_output, current_address,
      output cpu_rdata, cpu_ready, cpu_busy, cpu_err,
      output sdram_buffer_addr_in, sdram_buffer_data_in, sdram_buffer_rw_in, sdram_buffer_wrreq
   );

   modport master (
      output cpu_addr, cpu_wdata, cpu_we, cpu_re,
      output sdram_buffer_full, sdram_buffer_empty, data_output, current_address,
      input  cpu_rdata, cpu_ready, cpu_busy, cpu_err,
      input  sdram_buffer_addr_in, sdram_buffer_data_in, sdram_buffer_rw_in, sdram_buffer_wrreq
   );
endinterface

// File: rtl/sdram_request_port.sv
// CPU-side requester feeding the SDRAM request FIFO: posted writes, blocking reads with timeout.
// Optional single-entry write-to-read forwarding is enabled with SDRAM_WRITE_FORWARD_EN.
module sdram_request_port #(
   parameter int unsigned ADDR_W         = 20,
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input logic                 clk100_0ds,
   input logic                 rst_n,
   sdram_request_port_if.slave bus
);
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {StIdle, StWrPush, StRdPush, StRdWait, StDone} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              rw_q, rw_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              wrreq;

`ifdef SDRAM_WRITE_FORWARD_EN
   logic              fwd_valid_q, fwd_valid_d;
   logic [ADDR_W-1:0] fwd_addr_q, fwd_addr_d;
   logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rw_d    = rw_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      wrreq   = 1'b0;
`ifdef SDRAM_WRITE_FORWARD_EN
      fwd_valid_d = fwd_valid_q;
      fwd_addr_d  = fwd_addr_q;
      fwd_data_d  = fwd_data_q;
`endif
      unique case (state_q)
         StIdle: begin
            // Write wins over a simultaneous read; the dropped read must be re-issued.
            if (bus.cpu_we) begin
               addr_d  = bus.cpu_addr;
               data_d  = bus.cpu_wdata;
               rw_d    = 1'b1;
               state_d = StWrPush;
`ifdef SDRAM_WRITE_FORWARD_EN
               fwd_valid_d = 1'b1;
               fwd_addr_d  = bus.cpu_addr;
               fwd_data_d  = bus.cpu_wdata;
`endif
            end else if (bus.cpu_re) begin
`ifdef SDRAM_WRITE_FORWARD_EN
               // Forwarded reads create no FIFO entry, so the entry outputs keep their values.
               if (fwd_valid_q && (bus.cpu_addr == fwd_addr_q)) begin
                  rdata_d = fwd_data_q;
                  state_d = StDone;
               end else
`endif
               begin
                  addr_d  = bus.cpu_addr;
                  data_d  = '0;
                  rw_d    = 1'b0;
                  state_d = StRdPush;
               end
            end
         end
         StWrPush: begin
            if (!bus.sdram_buffer_full) begin
               wrreq   = 1'b1;
               state_d = StDone;
            end
         end
         StRdPush: begin
            if (!bus.sdram_buffer_full) begin
               wrreq   = 1'b1;
               cnt_d   = '0;
               state_d = StRdWait;
            end
         end
         StRdWait: begin
            // The first two wait cycles are skipped to cover the FIFO empty-flag latency.
            if ((cnt_q >= CntW'(2)) && bus.sdram_buffer_empty &&
                (bus.current_address == addr_q)) begin
               rdata_d = bus.data_output;
               state_d = StDone;
            end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               rdata_d = '1;
               state_d = StDone;
            end
            if (cnt_q != CntW'(TIMEOUT_CYCLES)) begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk100_0ds) begin
      if (!rst_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         data_q  <= '0;
         rw_q    <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef SDRAM_WRITE_FORWARD_EN
         fwd_valid_q <= 1'b0;
         fwd_addr_q  <= '0;
         fwd_data_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rw_q    <= rw_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef SDRAM_WRITE_FORWARD_EN
         fwd_valid_q <= fwd_valid_d;
         fwd_addr_q  <= fwd_addr_d;
         fwd_data_q  <= fwd_data_d;
`endif
      end
   end

   assign bus.cpu_rdata            = rdata_q;
   assign bus.cpu_ready            = (state_q == StDone);
   assign bus.cpu_busy             = (state_q != StIdle);
   assign bus.cpu_err              = err_q;
   assign bus.sdram_buffer_addr_in = addr_q;
   assign bus.sdram_buffer_data_in = data_q;
   assign bus.sdram_buffer_rw_in   = rw_q;
   assign bus.sdram_buffer_wrreq   = wrreq;
endmodule

// File: tb/tb_sdram_request_port.sv
// Self-checking bench for sdram_request_port: directed scenarios plus random transactions
// scored against a cycle-count model of the request/complete rules.
module tb_sdram_request_port;
   localparam int unsigned TO = 15;
`ifdef SDRAM_WRITE_FORWARD_EN
   localparam bit FwdEn = 1'b1;
`else
   localparam bit FwdEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // Reference model state: sticky error flag and last accepted write.
   bit          m_err = 1'b0;
   bit          m_fwd_valid = 1'b0;
   logic [19:0] m_fwd_addr = '0;
   logic [15:0] m_fwd_data = '0;

   always #5 clk = ~clk;

   sdram_request_port_if #(.ADDR_W(20), .DATA_W(16)) bus ();

   sdram_request_port #(
      .ADDR_W(20),
      .DATA_W(16),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk100_0ds(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One CPU access. Cycle c counts clock periods after the acceptance edge; the FIFO is full
   // for cycles 1..nfull, empty from empty_cyc, and current_address matches from match_cyc.
   task automatic do_txn(input string tag, input bit we, input bit re, input logic [19:0] a,
                         input logic [15:0] d, input int nfull, input int match_cyc,
                         input int empty_cyc, input logic [15:0] rd_val);
      bit          exp_push;
      bit          exp_rw;
      logic [15:0] exp_pdata;
      logic [15:0] exp_rdata;
      bit          is_read;
      int          exp_k;
      int          pr;
      int          w;
      int          k;
      int          npush;
      int          busy_bad;
      logic [19:0] p_addr;
      logic [15:0] p_data;
      logic        p_rw;
      logic [15:0] got_rdata;

      is_read   = re && !we;
      exp_rdata = '0;
      exp_pdata = '0;
      exp_rw    = 1'b0;
      if (we) begin
         exp_push  = 1'b1;
         exp_rw    = 1'b1;
         exp_pdata = d;
         exp_k     = nfull + 2;
         if (FwdEn) begin
            m_fwd_valid = 1'b1;
            m_fwd_addr  = a;
            m_fwd_data  = d;
         end
      end else if (FwdEn && m_fwd_valid && (a == m_fwd_addr)) begin
         exp_push  = 1'b0;
         exp_k     = 1;
         exp_rdata = m_fwd_data;
      end else begin
         exp_push = 1'b1;
         pr = nfull + 1;
         w  = pr + 3;
         if (match_cyc > w) w = match_cyc;
         if (empty_cyc > w) w = empty_cyc;
         if (w <= pr + int'(TO)) begin
            exp_k     = w + 1;
            exp_rdata = rd_val;
         end else begin
            exp_k     = pr + int'(TO) + 1;
            exp_rdata = 16'hFFFF;
            m_err     = 1'b1;
         end
      end

      bus.cpu_addr           = a;
      bus.cpu_wdata          = d;
      bus.cpu_we             = we;
      bus.cpu_re             = re;
      bus.sdram_buffer_full  = (nfull > 0);
      bus.sdram_buffer_empty = 1'b0;
      bus.current_address    = ~a;
      @(posedge clk);
      #1;
      bus.cpu_we = 1'b0;
      bus.cpu_re = 1'b0;
      k = -1; npush = 0; busy_bad = 0;
      p_addr = '0; p_data = '0; p_rw = 1'b0; got_rdata = '0;
      for (int c = 1; c <= 64; c++) begin
         bus.sdram_buffer_full  = (c <= nfull);
         bus.sdram_buffer_empty = (c >= empty_cyc);
         bus.current_address    = (c >= match_cyc) ? a : ~a;
         bus.data_output        = rd_val;
         @(negedge clk);
         if (bus.sdram_buffer_wrreq === 1'b1) begin
            npush++;
            p_addr = bus.sdram_buffer_addr_in;
            p_data = bus.sdram_buffer_data_in;
            p_rw   = bus.sdram_buffer_rw_in;
         end
         if (bus.cpu_busy !== 1'b1) busy_bad++;
         if (bus.cpu_ready === 1'b1) begin
            k = c;
            got_rdata = bus.cpu_rdata;
            break;
         end
         @(posedge clk);
         #1;
      end

      chk({tag, "/ready_cycle"}, 32'(k), 32'(exp_k));
      chk({tag, "/push_count"}, 32'(npush), 32'(exp_push));
      chk({tag, "/busy_low_while_active"}, 32'(busy_bad), 32'd0);
      if (exp_push) begin
         chk({tag, "/entry"}, {11'd0, p_rw, p_data, p_addr[3:0]}, {11'd0, exp_rw, exp_pdata, a[3:0]});
         chk({tag, "/entry_addr"}, {12'd0, p_addr}, {12'd0, a});
      end
      if (is_read) chk({tag, "/rdata"}, {16'd0, got_rdata}, {16'd0, exp_rdata});
      chk({tag, "/err"}, {31'd0, bus.cpu_err}, {31'd0, m_err});

      @(posedge clk);
      #1;
      bus.sdram_buffer_full  = 1'b0;
      bus.sdram_buffer_empty = 1'b1;
      @(negedge clk);
      chk({tag, "/idle_after"}, {30'd0, bus.cpu_busy, bus.cpu_ready}, 32'd0);
      if (exp_push) chk({tag, "/entry_hold"}, {12'd0, bus.sdram_buffer_addr_in}, {12'd0, a});
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [19:0] ra;
      logic [15:0] rd;
      int          kind;
      int          nf;
      int          mc;
      int          ec;
      int          stray;

      bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_we = 1'b0; bus.cpu_re = 1'b0;
      bus.sdram_buffer_full = 1'b0; bus.sdram_buffer_empty = 1'b1;
      bus.data_output = '0; bus.current_address = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset/cpu", {13'd0, bus.cpu_ready, bus.cpu_busy, bus.cpu_err, bus.cpu_rdata}, 32'd0);
      chk("reset/fifo", {10'd0, bus.sdram_buffer_wrreq, bus.sdram_buffer_rw_in,
          bus.sdram_buffer_addr_in}, 32'd0);
      chk("reset/fifo_data", {16'd0, bus.sdram_buffer_data_in}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_txn("wr_basic", 1'b1, 1'b0, 20'h00010, 16'hBEEF, 0, 1, 1, 16'h0);
      do_txn("wr_full", 1'b1, 1'b0, 20'h00011, 16'hCAFE, 5, 1, 1, 16'h0);
      do_txn("wr_q0", 1'b1, 1'b0, 20'h00012, 16'h1111, 0, 1, 1, 16'h0);
      do_txn("wr_q1", 1'b1, 1'b0, 20'h00013, 16'h2222, 0, 1, 1, 16'h0);
      do_txn("wr_q2", 1'b1, 1'b0, 20'h00014, 16'h3333, 0, 1, 1, 16'h0);
      do_txn("rd_after_wr", 1'b0, 1'b1, 20'h00020, 16'h0, 0, 1, 9, 16'h1234);
      do_txn("rd_earliest", 1'b0, 1'b1, 20'h00021, 16'h0, 0, 1, 1, 16'h4321);
      do_txn("we_re_both", 1'b1, 1'b1, 20'h00030, 16'h5555, 0, 1, 1, 16'h9999);
      do_txn("rd_timeout", 1'b0, 1'b1, 20'h00040, 16'h0, 0, 1000, 1, 16'h7777);
      do_txn("err_sticky", 1'b1, 1'b0, 20'h00041, 16'h6666, 0, 1, 1, 16'h0);
      do_txn("fwd_wr", 1'b1, 1'b0, 20'h00005, 16'hA5A5, 0, 1, 1, 16'h0);
      do_txn("fwd_rd_hit", 1'b0, 1'b1, 20'h00005, 16'h0, 0, 1, 1, 16'h0BAD);
      do_txn("fwd_rd_miss", 1'b0, 1'b1, 20'h00006, 16'h0, 0, 1, 1, 16'h5A5A);

      for (int i = 0; i < 24; i++) begin
         kind = int'($urandom_range(0, 2));
         ra   = 20'($urandom);
         if (m_fwd_valid && ($urandom_range(0, 3) == 0)) ra = m_fwd_addr;
         rd = 16'($urandom);
         nf = int'($urandom_range(0, 3));
         mc = int'($urandom_range(1, 12));
         ec = int'($urandom_range(1, 12));
         if ($urandom_range(0, 7) == 0) mc = 100;
         do_txn($sformatf("rand%0d", i), kind != 1, kind != 0, ra, 16'($urandom), nf, mc, ec, rd);
      end

      // Reset while a read waits: outputs clear, and a later match must not complete anything.
      bus.cpu_addr = 20'h00077; bus.cpu_re = 1'b1;
      bus.current_address = 20'h00000; bus.sdram_buffer_empty = 1'b1;
      @(posedge clk);
      #1;
      bus.cpu_re = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("midrd/busy_before_reset", {31'd0, bus.cpu_busy}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midrd/cpu_zero", {13'd0, bus.cpu_ready, bus.cpu_busy, bus.cpu_err, bus.cpu_rdata}, 32'd0);
      chk("midrd/fifo_zero", {10'd0, bus.sdram_buffer_wrreq, bus.sdram_buffer_rw_in,
          bus.sdram_buffer_addr_in}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_err = 1'b0;
      m_fwd_valid = 1'b0;
      bus.current_address = 20'h00077;
      bus.data_output = 16'hDEAD;
      stray = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.cpu_ready !== 1'b0 || bus.cpu_busy !== 1'b0) stray++;
      end
      chk("midrd/no_stray_ready", 32'(stray), 32'd0);
      @(posedge clk);
      #1;
      do_txn("post_reset_rd", 1'b0, 1'b1, 20'h00005, 16'h0, 0, 1, 1, 16'h0F0F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
